controller_sequencer: RTL
=========================

// Module: controller_sequencer
// PURPOSE
//   SAP-1 control unit. Six-state ring counter (T1..T6) plus opcode decode.
//   Drives the control word for PC, MAR, RAM, IR, accumulator, B register,
//   adder_subtracter (su, eu) and output register.
//   It is the initiating end of the adder_subtracter interface: it decides when
//   SUB is asserted and when the sum is put on the bus and latched into A.
// PARAMETERS
//   OP_W    4        opcode width (IR upper nibble)
//   OP_LDA  4'b0000  load A from memory
//   OP_ADD  4'b0001  A <= A + mem
//   OP_SUB  4'b0010  A <= A - mem
//   OP_OUT  4'b1110  output register <= A
//   OP_HLT  4'b1111  stop sequencing
// PORTS
//   clk      in   1     system clock; all state changes on rising edge
//   clr      in   1     asynchronous, active-high reset
//   opcode   in   OP_W  IR[7:4]; sampled combinationally during T4..T6
//   cp       out  1     increment PC
//   ep       out  1     PC drives bus
//   lm       out  1     load MAR from bus
//   ce       out  1     RAM drives bus
//   li       out  1     load IR from bus
//   ei       out  1     IR operand nibble drives bus
//   la       out  1     load accumulator from bus
//   ea       out  1     accumulator drives bus
//   su       out  1     SUB input of adder_subtracter (1 = A - B)
//   eu       out  1     adder_subtracter drives bus
//   lb       out  1     load B register from bus
//   lo       out  1     load output register from bus
//   hlt      out  1     halted flag; stays high until clr
//   t_state  out  6     one-hot ring state, bit0 = T1 ... bit5 = T6
// BEHAVIOUR
//   - All control outputs are active-high.
//   - Control outputs are decoded combinationally from t_state, opcode and hlt.
//   - Control outputs are not registered: they are valid within the current T-state.
//   - Ring register: one-hot. Rising clk advances T1->T2->...->T6->T1 while hlt=0.
//   - clr=1 (async): t_state=6'b000001, hlt=0. All controls then decode as T1.
//   - clr mid-instruction aborts immediately. Downstream regs are cleared by their own clr.
//   - Fetch, same for every opcode:
//       T1: ep, lm
//       T2: cp
//       T3: ce, li
//   - Execute:
//       LDA: T4 ei,lm | T5 ce,la | T6 none
//       ADD: T4 ei,lm | T5 ce,lb | T6 eu,la (su=0)
//       SUB: T4 ei,lm | T5 ce,lb | T6 su,eu,la
//       OUT: T4 ea,lo | T5 none  | T6 none
//       HLT: T4 none; on the rising edge ending T4, hlt<=1 and t_state stays 6'b001000.
//       Undefined opcode: T4..T6 none (NOP), 6 cycles.
//   - su is asserted only together with eu in SUB T6; su=0 in every other state.
//   - At most one bus driver per state (ep, ce, ei, ea, eu mutually exclusive).
//     The bench asserts this.
//   - hlt=1: ring frozen, every control output 0, opcode ignored. Only clr exits.
//   - Every instruction takes exactly 6 clocks. The T6->T1 wrap is unconditional.
//   - An opcode change during T1..T3 has no effect on the outputs.
//   - An illegal ring value (not one-hot) is recovered to T1 on the next clock.
// TESTING
//   1. clr pulse mid-T4 (async, between edges) -> t_state=000001 at once; ep=lm=1; hlt=0.
//   2. Free run, opcode=OP_LDA -> t_state cycles 1,2,4,8,16,32,1.
//      Controls per table each state; exactly one bus driver per state.
//   3. opcode=OP_SUB -> at T6: su=1, eu=1, la=1, lb=0.
//      With the datapath attached, A=3, mem=1 -> A becomes 8'b00000010.
//   4. opcode=OP_ADD, datapath A=1, mem=2 -> T6 su=0, eu=la=1; A becomes 8'b00000011.
//   5. opcode=OP_HLT -> after the T4 edge, hlt=1 and t_state=001000.
//      Held for 20 clocks with all controls 0. Then clr -> T1, hlt=0.
//   6. opcode=4'b0101 (undefined) -> T4..T6 all controls 0; wraps to T1 after 6 clocks.

Source files
------------

// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 control unit, one-hot T1..T6 ring with opcode decode
module controller_sequencer #(
  parameter int OP_W = 4,
  parameter logic [OP_W-1:0] OP_LDA = 4'b0000,
  parameter logic [OP_W-1:0] OP_ADD = 4'b0001,
  parameter logic [OP_W-1:0] OP_SUB = 4'b0010,
  parameter logic [OP_W-1:0] OP_OUT = 4'b1110,
  parameter logic [OP_W-1:0] OP_HLT = 4'b1111
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [OP_W-1:0] opcode,
  output logic            cp,
  output logic            ep,
  output logic            lm,
  output logic            ce,
  output logic            li,
  output logic            ei,
  output logic            la,
  output logic            ea,
  output logic            su,
  output logic            eu,
  output logic            lb,
  output logic            lo,
  output logic            hlt,
  output logic [5:0]      t_state
);
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;
  ring_t state, state_n;
  logic hlt_n;
  logic t1, t2, t3, t4, t5, t6;
  logic lda, add, sub, out, mem_op, alu_op;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= T1;
      hlt   <= 1'b0;
    end else begin
      state <= state_n;
      hlt   <= hlt_n;
    end
  // Any non-one-hot ring value falls through to T1 via the default arm.
  always_comb begin
    state_n = T1;
    hlt_n   = hlt;
    if (hlt)
      state_n = state;
    else if (state == T4 && opcode == OP_HLT) begin
      state_n = state;
      hlt_n   = 1'b1;
    end else
      case (state)
        T1:      state_n = T2;
        T2:      state_n = T3;
        T3:      state_n = T4;
        T4:      state_n = T5;
        T5:      state_n = T6;
        default: state_n = T1;
      endcase
  end
  assign t1 = ~hlt & (state == T1);
  assign t2 = ~hlt & (state == T2);
  assign t3 = ~hlt & (state == T3);
  assign t4 = ~hlt & (state == T4);
  assign t5 = ~hlt & (state == T5);
  assign t6 = ~hlt & (state == T6);
  assign lda    = opcode == OP_LDA;
  assign add    = opcode == OP_ADD;
  assign sub    = opcode == OP_SUB;
  assign out    = opcode == OP_OUT;
  assign alu_op = add | sub;
  assign mem_op = lda | alu_op;
  assign ep = t1;
  assign cp = t2;
  assign li = t3;
  assign lm = t1 | (t4 & mem_op);
  assign ce = t3 | (t5 & mem_op);
  assign ei = t4 & mem_op;
  assign ea = t4 & out;
  assign lo = t4 & out;
  assign la = (t5 & lda) | (t6 & alu_op);
  assign lb = t5 & alu_op;
  assign eu = t6 & alu_op;
  assign su = t6 & sub;
  assign t_state = state;
endmodule
